softmax_row_wb_scheduler: RTL and testbench

- Sequences the write-back of completed softmax rows into the shared output row memory.
- NUM_REQ row producers (softmax lanes) each raise a request with a 32-element row. The block round-robin arbitrates between them, snapshots the granted row, and serialises it one element per accepted beat onto a single memory write port with valid/ready backpressure.
- Replaces the free-running per-row flatten logic. Multiple lanes now share one write port under explicit scheduling.

---
 rtl/softmax_row_wb_scheduler_pkg.sv | 17 +
 rtl/softmax_row_wb_scheduler_rr_arbiter.sv | 45 ++++
 rtl/softmax_row_wb_scheduler.sv | 162 ++++++++++++++++
 tb/tb_softmax_row_wb_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_row_wb_scheduler_pkg.sv
// Shared types and constants for the softmax row write-back scheduler.
package softmax_wb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int unsigned DEF_ROW_LEN = 32;
  localparam int unsigned DEF_DATA_W  = 16;

  // Width of a binary id able to name n items (at least one bit).
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_row_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, wrapping, wins. Shared by blocks that multiplex onto one port.
module rr_arbiter
  import softmax_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    id_o
);

  logic [ID_W:0]   sum_s;
  logic [ID_W-1:0] lane_s;
  logic            found_s;

  // Scan lanes upward from the pointer and grant the first requester.
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    found_s = 1'b0;
    sum_s   = '0;
    lane_s  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      sum_s = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (sum_s >= (ID_W+1)'(NUM_REQ)) begin
        sum_s = sum_s - (ID_W+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      lane_s = sum_s[ID_W-1:0];
      if (en_i && !found_s && req_i[lane_s]) begin
        found_s       = 1'b1;
        gnt_o[lane_s] = 1'b1;
        id_o          = lane_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/softmax_row_wb_scheduler.sv
// Round-robin write-back scheduler: snapshots a granted softmax row and
// streams it one element per accepted beat onto the shared write port.
module softmax_row_wb_scheduler
  import softmax_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ROW_LEN = DEF_ROW_LEN,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = 10,
  localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [DATA_W-1:0]  i_row [NUM_REQ][ROW_LEN],
  input  logic [ADDR_W-1:0]  i_base_addr,
  output logic [NUM_REQ-1:0] o_ack,
  output logic               o_wr_en,
  input  logic               i_wr_ready,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [DATA_W-1:0]  o_wr_data,
  output logic               o_row_done,
  output logic [ID_W-1:0]    o_done_id,
  output logic               o_busy
);

  localparam int unsigned IDX_W = id_width(ROW_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   buf_q [ROW_LEN];

  logic [NUM_REQ-1:0]  gnt_s;
  logic [ID_W-1:0]     gnt_id_s;
  logic                grant_s;
  logic [IDX_W-1:0]    idx_nxt_s;
  logic [ADDR_W-1:0]   off_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (i_req),
    .ptr_i (rr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt_s),
    .id_o  (gnt_id_s)
  );

  assign grant_s   = |gnt_s;
  assign idx_nxt_s = idx_q + IDX_W'(1);
  assign off_s     = ADDR_W'(gnt_id_s) * ADDR_W'(ROW_LEN);

  // Next-state and registered-output logic for the grant/stream sequence.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cur_id_d  = cur_id_q;
    idx_d     = idx_q;
    ack_d     = '0;
    wr_en_d   = wr_en_q;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          ack_d    = gnt_s;
          wr_en_d  = 1'b1;
          addr_d   = i_base_addr + off_s;
          data_d   = i_row[gnt_id_s][0];
          idx_d    = '0;
          cur_id_d = gnt_id_s;
          state_d  = STREAM;
          rr_d     = (gnt_id_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
        end else begin
          wr_en_d = 1'b0;
          addr_d  = '0;
          data_d  = '0;
        end
      end
      STREAM: begin
        if (i_wr_ready) begin
          if (idx_q == LAST_IDX) begin
            wr_en_d   = 1'b0;
            addr_d    = '0;
            data_d    = '0;
            done_d    = 1'b1;
            done_id_d = cur_id_q;
            state_d   = IDLE;
          end else begin
            idx_d  = idx_nxt_s;
            addr_d = addr_q + ADDR_W'(1);
            data_d = buf_q[idx_nxt_s];
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
      end
    endcase
    busy_d = (state_d == STREAM);
  end

  // Control and output registers; reset aborts any in-flight row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      cur_id_q  <= '0;
      idx_q     <= '0;
      ack_q     <= '0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cur_id_q  <= cur_id_d;
      idx_q     <= idx_d;
      ack_q     <= ack_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
    end
  end

  // Row snapshot at grant so the producer may reuse its buffer after ack.
  always_ff @(posedge i_clk) begin
    if (grant_s) begin
      buf_q <= i_row[gnt_id_s];
    end
  end

  assign o_ack      = ack_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = addr_q;
  assign o_wr_data  = data_q;
  assign o_row_done = done_q;
  assign o_done_id  = done_id_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_softmax_row_wb_scheduler.sv
// Scoreboard bench for softmax_row_wb_scheduler: directed rows push the
// expected acks, beats and done ids; a negedge monitor pops and compares.
module tb_softmax_row_wb_scheduler;

  localparam int N  = 4;
  localparam int L  = 32;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [DW-1:0] row [N][L];
  logic [AW-1:0] base;
  logic          rdy;
  logic [N-1:0]  o_ack;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_row_done;
  logic [1:0]    o_done_id;
  logic          o_busy;

  softmax_row_wb_scheduler #(.NUM_REQ(N), .ROW_LEN(L), .DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_row(row), .i_base_addr(base),
    .o_ack(o_ack), .o_wr_en(o_wr_en), .i_wr_ready(rdy), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_row_done(o_row_done), .o_done_id(o_done_id),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];
  int            q_ack  [$];
  int            q_done [$];
  int            beats_in_row = 0;
  int            acks_seen = 0;
  logic          hold_pend = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dval(input int salt, input int lane, input int k);
    return DW'(salt * 1000 + lane * 100 + k);
  endfunction

  task automatic set_rows(input int salt);
    for (int l = 0; l < N; l++)
      for (int k = 0; k < L; k++)
        row[l][k] = dval(salt, l, k);
  endtask

  task automatic push_row(input int lane, input int b, input int salt);
    q_ack.push_back(lane);
    for (int k = 0; k < L; k++) begin
      q_addr.push_back(AW'(b + lane * L + k));
      q_data.push_back(dval(salt, lane, k));
    end
    q_done.push_back(lane);
  endtask

  // Monitor: compare every accepted beat, ack and done against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      beats_in_row = 0;
      hold_pend    = 1'b0;
    end else begin
      if (hold_pend && o_wr_en) begin
        chk("stall_addr", o_wr_addr, hold_addr);
        chk("stall_data", o_wr_data, hold_data);
      end
      hold_pend = o_wr_en && !rdy;
      hold_addr = o_wr_addr;
      hold_data = o_wr_data;
      if (o_wr_en && rdy) begin
        if (q_addr.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          chk("beat_addr", o_wr_addr, q_addr.pop_front());
          chk("beat_data", o_wr_data, q_data.pop_front());
        end
        beats_in_row++;
      end
      if (o_ack != '0) begin
        acks_seen++;
        if (q_ack.size() == 0) chk("unexpected_ack", o_ack, 0);
        else chk("ack_lane", o_ack, 64'(1) << q_ack.pop_front());
      end
      if (o_row_done) begin
        chk("row_beats", beats_in_row, L);
        beats_in_row = 0;
        if (q_done.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_id", o_done_id, q_done.pop_front());
      end
    end
  end

  task automatic wait_ack(input int lane);
    int n = 0;
    while (!o_ack[lane] && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("ack_wait_lane%0d", lane), o_ack[lane], 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!o_row_done && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("done_wait", o_row_done, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q_addr.size() != 0 || q_done.size() != 0 || o_busy || o_row_done) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", {o_busy, o_wr_en, 30'(q_addr.size() + q_done.size())}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int n;
    rst = 1'b1; req = '0; rdy = 1'b1; base = '0;
    set_rows(1);
    #12;
    chk("rst_outputs", {o_ack, o_wr_en, o_wr_addr, o_wr_data, o_row_done, o_done_id, o_busy}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single lane 0, base 0; later row/base changes must not leak in.
    push_row(0, 0, 1);
    req = 4'b0001;
    @(posedge clk); #1;
    chk("t1_ack_latency", o_ack, 4'b0001);
    chk("t1_first_beat", {o_wr_en, o_busy, o_wr_addr, o_wr_data}, {1'b1, 1'b1, 10'd0, dval(1, 0, 0)});
    req = '0; set_rows(2); base = 10'd300;
    wait_idle();

    // Lanes 1 and 3 together from pointer 0, base 64, one bubble between rows.
    do_reset();
    base = 10'd64; set_rows(3);
    push_row(1, 64, 3); push_row(3, 64, 3);
    req = 4'b1010;
    wait_ack(1); req[1] = 1'b0;
    wait_done();
    @(posedge clk); #1;
    chk("t2_bubble_ack", o_ack, 4'b1000);
    req[3] = 1'b0;
    wait_idle();

    // Backpressure on lane 2 with ready pattern 1,0,0,1.
    base = 10'd5; set_rows(4);
    push_row(2, 5, 4);
    req = 4'b0100;
    n = 0;
    while ((q_done.size() != 0 || o_busy || n < 2) && n < 500) begin
      rdy = (n % 4 == 0) || (n % 4 == 3);
      @(posedge clk); #1; n++;
      if (o_ack[2]) req[2] = 1'b0;
    end
    rdy = 1'b1;
    wait_idle();

    // Fairness: all lanes hold requests for 8 rows.
    do_reset();
    base = 10'd200; set_rows(5);
    for (int r = 0; r < 8; r++) push_row(r % 4, 200, 5);
    a0 = acks_seen;
    req = 4'hF;
    n = 0;
    while (acks_seen - a0 < 8 && n < 600) begin
      @(posedge clk); #1; n++;
    end
    req = '0;
    chk("t4_ack_count", acks_seen - a0, 8);
    wait_idle();

    // Address wrap from base 1020.
    base = 10'd1020; set_rows(6);
    push_row(0, 1020, 6);
    req = 4'b0001;
    wait_ack(0); req = '0;
    wait_idle();

    // Reset at beat 10, then lane 2 restarts from element 0.
    base = 10'd0; set_rows(7);
    push_row(1, 0, 7);
    req = 4'b0010;
    wait_ack(1); req = '0;
    n = 0;
    while (beats_in_row < 10 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("t6_reached_beat10", beats_in_row >= 10, 1);
    #1 rst = 1'b1;
    q_addr.delete(); q_data.delete(); q_ack.delete(); q_done.delete();
    #1;
    chk("t6_async_rst", {o_ack, o_wr_en, o_wr_addr, o_wr_data, o_row_done, o_done_id, o_busy}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_held_rst", {o_wr_en, o_row_done, o_busy}, 0);
    rst = 1'b0;
    push_row(2, 0, 7);
    req = 4'b0100;
    @(posedge clk); #1;
    chk("t6_regrant_ack", o_ack, 4'b0100);
    chk("t6_regrant_beat", {o_wr_addr, o_wr_data}, {10'd64, dval(7, 2, 0)});
    req = '0;
    wait_idle();

    chk("queues_empty", q_addr.size() + q_ack.size() + q_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
